// File: rtl/mips_pkg.sv
// Shared encodings for the pipelined MIPS datapath: ALU operand-B source and
// rt forwarding source.
package mips_pkg;

  typedef enum logic [1:0] {
    SRC_REG   = 2'd0,
    SRC_IMM   = 2'd1,
    SRC_SHAMT = 2'd2,
    SRC_RSVD  = 2'd3
  } alu_src_e;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  localparam int unsigned ALU_SRC_W = 2;
  localparam int unsigned FWD_SEL_W = 2;

endpackage

// File: rtl/rt_forward_select.sv
// Combinational RAW-hazard resolution for the rt operand. The younger EX/MEM
// result beats MEM/WB, and register 0 is never forwarded.
module rt_forward_select
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [WIDTH-1:0]  rf_data_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] ex_mem_rd_i,
  input  logic              ex_mem_reg_write_i,
  input  logic [WIDTH-1:0]  ex_mem_result_i,
  input  logic [REG_AW-1:0] mem_wb_rd_i,
  input  logic              mem_wb_reg_write_i,
  input  logic [WIDTH-1:0]  mem_wb_result_i,
  output fwd_sel_e          fwd_o,
  output logic [WIDTH-1:0]  rtval_o
);

  logic rt_nonzero;
  logic ex_mem_hit;
  logic mem_wb_hit;

  assign rt_nonzero = (rt_i != '0);
  assign ex_mem_hit = ex_mem_reg_write_i && (ex_mem_rd_i == rt_i) && rt_nonzero;
  assign mem_wb_hit = mem_wb_reg_write_i && (mem_wb_rd_i == rt_i) && rt_nonzero;

  always_comb begin
    fwd_o   = FWD_NONE;
    rtval_o = rf_data_i;
    if (ex_mem_hit) begin
      fwd_o   = FWD_EXMEM;
      rtval_o = ex_mem_result_i;
    end else if (mem_wb_hit) begin
      fwd_o   = FWD_MEMWB;
      rtval_o = mem_wb_result_i;
    end
  end

endmodule

// File: rtl/alu_b_operand_stage.sv
// Forwarding-aware ALU operand-B select registered into the ID/EX boundary,
// with stall/flush control and forwarded store data for SW.
module alu_b_operand_stage
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   Q2,
  input  logic [WIDTH-1:0]   Extended32,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic [1:0]         ALUSrc,
  input  logic [REG_AW-1:0]  Rt,
  input  logic [REG_AW-1:0]  ExMemRd,
  input  logic               ExMemRegWrite,
  input  logic [WIDTH-1:0]   ExMemResult,
  input  logic [REG_AW-1:0]  MemWbRd,
  input  logic               MemWbRegWrite,
  input  logic [WIDTH-1:0]   MemWbResult,
  input  logic               InValid,
  input  logic               Stall,
  input  logic               Flush,
  output logic [WIDTH-1:0]   ALU_B,
  output logic [WIDTH-1:0]   StoreData,
  output logic [1:0]         FwdSel,
  output logic               OutValid
);

  fwd_sel_e         fwd;
  logic [WIDTH-1:0] rtval;
  logic [WIDTH-1:0] alu_b_sel;

  logic [WIDTH-1:0] alu_b_d,      alu_b_q;
  logic [WIDTH-1:0] store_data_d, store_data_q;
  fwd_sel_e         fwd_sel_d,    fwd_sel_q;
  logic             out_valid_d,  out_valid_q;

  rt_forward_select #(
    .WIDTH  (WIDTH),
    .REG_AW (REG_AW)
  ) u_rt_forward_select (
    .rf_data_i          (Q2),
    .rt_i               (Rt),
    .ex_mem_rd_i        (ExMemRd),
    .ex_mem_reg_write_i (ExMemRegWrite),
    .ex_mem_result_i    (ExMemResult),
    .mem_wb_rd_i        (MemWbRd),
    .mem_wb_reg_write_i (MemWbRegWrite),
    .mem_wb_result_i    (MemWbResult),
    .fwd_o              (fwd),
    .rtval_o            (rtval)
  );

  always_comb begin
    alu_b_sel = '0;
    unique case (alu_src_e'(ALUSrc))
      SRC_REG:   alu_b_sel = rtval;
      SRC_IMM:   alu_b_sel = Extended32;
      SRC_SHAMT: alu_b_sel = WIDTH'(Shamt);
      SRC_RSVD:  alu_b_sel = '0;
      default:   alu_b_sel = '0;
    endcase
  end

  // A stalled entry keeps its resolved value; it is not re-forwarded.
  always_comb begin
    alu_b_d      = alu_b_q;
    store_data_d = store_data_q;
    fwd_sel_d    = fwd_sel_q;
    out_valid_d  = out_valid_q;
    if (Flush) begin
      alu_b_d      = '0;
      store_data_d = '0;
      fwd_sel_d    = FWD_NONE;
      out_valid_d  = 1'b0;
    end else if (!Stall) begin
      alu_b_d      = alu_b_sel;
      store_data_d = rtval;
      fwd_sel_d    = fwd;
      out_valid_d  = InValid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_b_q      <= '0;
      store_data_q <= '0;
      fwd_sel_q    <= FWD_NONE;
      out_valid_q  <= 1'b0;
    end else begin
      alu_b_q      <= alu_b_d;
      store_data_q <= store_data_d;
      fwd_sel_q    <= fwd_sel_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign ALU_B     = alu_b_q;
  assign StoreData = store_data_q;
  assign FwdSel    = fwd_sel_q;
  assign OutValid  = out_valid_q;

endmodule

// File: tb/tb_alu_b_operand_stage.sv
// Directed bench for alu_b_operand_stage: reset, forwarding priority, operand
// modes and stall/flush control, checked with immediate assertions.
module tb_alu_b_operand_stage;

  logic        clk;
  logic        rst;
  logic [31:0] Q2;
  logic [31:0] Extended32;
  logic [4:0]  Shamt;
  logic [1:0]  ALUSrc;
  logic [4:0]  Rt;
  logic [4:0]  ExMemRd;
  logic        ExMemRegWrite;
  logic [31:0] ExMemResult;
  logic [4:0]  MemWbRd;
  logic        MemWbRegWrite;
  logic [31:0] MemWbResult;
  logic        InValid;
  logic        Stall;
  logic        Flush;
  logic [31:0] ALU_B;
  logic [31:0] StoreData;
  logic [1:0]  FwdSel;
  logic        OutValid;

  int checks = 0;
  int errors = 0;

  alu_b_operand_stage #(
    .WIDTH   (32),
    .REG_AW  (5),
    .SHAMT_W (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Q2            (Q2),
    .Extended32    (Extended32),
    .Shamt         (Shamt),
    .ALUSrc        (ALUSrc),
    .Rt            (Rt),
    .ExMemRd       (ExMemRd),
    .ExMemRegWrite (ExMemRegWrite),
    .ExMemResult   (ExMemResult),
    .MemWbRd       (MemWbRd),
    .MemWbRegWrite (MemWbRegWrite),
    .MemWbResult   (MemWbResult),
    .InValid       (InValid),
    .Stall         (Stall),
    .Flush         (Flush),
    .ALU_B         (ALU_B),
    .StoreData     (StoreData),
    .FwdSel        (FwdSel),
    .OutValid      (OutValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] alu_b, input logic [31:0] sd,
                         input logic [1:0] fwd, input logic vld);
    chk({tag, ".alu_b"}, ALU_B, alu_b);
    chk({tag, ".store"}, StoreData, sd);
    chk({tag, ".fwd"}, {30'd0, FwdSel}, {30'd0, fwd});
    chk({tag, ".valid"}, {31'd0, OutValid}, {31'd0, vld});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; Q2 = '0; Extended32 = '0; Shamt = '0; ALUSrc = 2'd0; Rt = '0;
    ExMemRd = '0; ExMemRegWrite = 1'b0; ExMemResult = '0;
    MemWbRd = '0; MemWbRegWrite = 1'b0; MemWbResult = '0;
    InValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
    tick();
    tick();
    chk_all("reset_hold", 32'h0, 32'h0, 2'd0, 1'b0);

    // First edge after release loads register data
    rst = 1'b0; InValid = 1'b1; ALUSrc = 2'd0; Q2 = 32'h1234; Rt = 5'd3;
    tick();
    chk_all("first_load", 32'h1234, 32'h1234, 2'd0, 1'b1);

    // Mid-cycle async reset clears outputs before any edge
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 2'd0, 1'b0);
    tick();
    chk_all("rst_held", 32'h0, 32'h0, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("post_rst", 32'h1234, 32'h1234, 2'd0, 1'b1);

    // Double hazard: EX/MEM wins
    Rt = 5'd5;
    ExMemRd = 5'd5; ExMemRegWrite = 1'b1; ExMemResult = 32'hAAAA0000;
    MemWbRd = 5'd5; MemWbRegWrite = 1'b1; MemWbResult = 32'hBBBB0000;
    tick();
    chk_all("dbl_exmem", 32'hAAAA0000, 32'hAAAA0000, 2'd1, 1'b1);
    ExMemRegWrite = 1'b0;
    tick();
    chk_all("dbl_memwb", 32'hBBBB0000, 32'hBBBB0000, 2'd2, 1'b1);
    ExMemRegWrite = 1'b1; ExMemRd = 5'd6;
    tick();
    chk_all("exmem_miss", 32'hBBBB0000, 32'hBBBB0000, 2'd2, 1'b1);

    // Register 0 never forwards
    Rt = 5'd0; Q2 = 32'h0;
    ExMemRd = 5'd0; ExMemRegWrite = 1'b1; ExMemResult = 32'hFFFF;
    MemWbRd = 5'd0; MemWbRegWrite = 1'b1; MemWbResult = 32'h1111;
    tick();
    chk_all("reg0", 32'h0, 32'h0, 2'd0, 1'b1);

    // SW: immediate operand, forwarded store data
    ALUSrc = 2'd1; Extended32 = 32'hFFFFFFFC; Rt = 5'd7; Q2 = 32'h9999;
    ExMemRegWrite = 1'b0; MemWbRd = 5'd7; MemWbRegWrite = 1'b1; MemWbResult = 32'h55;
    tick();
    chk_all("sw_fwd", 32'hFFFFFFFC, 32'h55, 2'd2, 1'b1);

    // Shift mode zero-extends Shamt
    ALUSrc = 2'd2; Shamt = 5'd31; MemWbRegWrite = 1'b0;
    tick();
    chk_all("shamt", 32'h0000001F, 32'h9999, 2'd0, 1'b1);

    // Reserved mode yields zero operand
    ALUSrc = 2'd3;
    tick();
    chk_all("rsvd", 32'h0, 32'h9999, 2'd0, 1'b1);

    // Invalid instruction still loads data
    ALUSrc = 2'd0; Q2 = 32'h777; InValid = 1'b0;
    tick();
    chk_all("invalid", 32'h777, 32'h777, 2'd0, 1'b0);

    // Stall holds across input changes
    InValid = 1'b1; Q2 = 32'hCAFE;
    tick();
    chk_all("pre_stall", 32'hCAFE, 32'hCAFE, 2'd0, 1'b1);
    Stall = 1'b1; Q2 = 32'hDEAD; InValid = 1'b0;
    ExMemRd = 5'd7; ExMemRegWrite = 1'b1; ExMemResult = 32'h4242;
    tick();
    chk_all("stall1", 32'hCAFE, 32'hCAFE, 2'd0, 1'b1);
    ALUSrc = 2'd1; Extended32 = 32'h1;
    tick();
    chk_all("stall2", 32'hCAFE, 32'hCAFE, 2'd0, 1'b1);

    // Flush beats Stall
    Flush = 1'b1;
    tick();
    chk_all("flush_stall", 32'h0, 32'h0, 2'd0, 1'b0);

    Stall = 1'b0; Flush = 1'b0; ALUSrc = 2'd0; InValid = 1'b1; ExMemRegWrite = 1'b0;
    Q2 = 32'hBEEF;
    tick();
    chk_all("resume", 32'hBEEF, 32'hBEEF, 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
